// File: rtl/fphub_sqrt_arbiter.sv
// ---------------------------------------------------------------------------
// fphub_sqrt_arbiter
//
// Round-robin arbiter and sequencer that shares one iterative FPHUB square
// root unit among NREQ requesters. One operation is in flight at a time:
// the granted operand is latched, the unit is started with a one-cycle
// pulse, the arbiter waits for the unit's finish pulse, and the result is
// returned on a single valid/ready response channel tagged with the index
// of the requester that was served.
//
// Optional feature macro: FPHUB_SQRT_SPECIAL_EN
//   When defined, operands that are zero/denormal (exponent all zeros),
//   negative (sign set, exponent nonzero) or positive infinity/NaN
//   (exponent all ones, sign clear) bypass the unit and are answered
//   directly on the cycle after acceptance.
//   When undefined, every operand goes to the unit.
//
// Parameters
//   NREQ : number of requesters (>= 2)
//   M    : mantissa width
//   E    : exponent width
//   T    : operand MSB index (operands are T+1 bits)
//   IDW  : response id width
//
// Ports
//   clk        : clock
//   rst_l      : asynchronous active-low reset (shared with the sqrt unit)
//   req_valid  : per-requester request
//   req_x      : packed operands, requester i at [i*(T+1) +: T+1]
//   req_ready  : one-hot accept, only ever high while idle
//   rsp_valid  : result valid
//   rsp_ready  : consumer accepts result
//   rsp_id     : index of the served requester
//   rsp_res    : result
//   sq_start   : one-cycle start pulse to the sqrt unit
//   sq_x       : operand to the sqrt unit, held for the whole operation
//   sq_res     : result from the sqrt unit
//   sq_finish  : done pulse from the sqrt unit
//   busy       : high whenever the arbiter is not idle
// ---------------------------------------------------------------------------
module fphub_sqrt_arbiter #(
  parameter  int NREQ = 4,
  parameter  int M    = 23,
  parameter  int E    = 8,
  localparam int T    = M + E,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*(T+1)-1:0] req_x,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [T:0]            rsp_res,
  output logic                  sq_start,
  output logic [T:0]            sq_x,
  input  logic [T:0]            sq_res,
  input  logic                  sq_finish,
  output logic                  busy
);

  // Sequencer states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]      r_state;
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  r_gnt;
  logic [T:0]      r_sqX;
  logic [IDW-1:0]  r_rspId;
  logic [T:0]      r_rspRes;

  logic            w_found;
  logic [IDW-1:0]  w_gnt;
  logic            w_accept;
  logic [NREQ-1:0] w_readyVec;
  logic [T:0]      w_gntX;
  logic            w_special;
  logic [T:0]      w_specialRes;

  // Adds an offset to a requester index and wraps it back into 0..NREQ-1.
  // NREQ need not be a power of two, so the wrap is done explicitly rather
  // than by letting the index overflow.
  function automatic logic [IDW-1:0] wrapIdx(input logic [IDW-1:0] base,
                                             input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Round-robin search: the first valid requester at or after the pointer,
  // wrapping around. The pointer always sits one past the last requester
  // served, so every pending request is reached within NREQ grants.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && req_valid[wrapIdx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_gnt   = wrapIdx(r_ptr, k);
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;
  assign w_gntX   = req_x[int'(w_gnt)*(T+1) +: T+1];

  // One-hot accept for the winning requester, only while idle.
  always_comb begin
    w_readyVec = '0;
    if (w_accept) w_readyVec[w_gnt] = 1'b1;
  end

  // The accept is masked by reset at the port so a requester never sees a
  // handshake while the arbiter is held in reset.
  assign req_ready = w_readyVec & {NREQ{rst_l}};

`ifdef FPHUB_SQRT_SPECIAL_EN
  // Operand classification for the bypass path. The checks are ordered:
  // a zero exponent wins over the sign, so signed zeros come back
  // unchanged, and only nonzero-exponent negatives become the canonical
  // NaN (sign 0, exponent all ones, quiet bit set).
  always_comb begin
    w_special    = 1'b0;
    w_specialRes = w_gntX;
    if (w_gntX[T-1:M] == '0) begin
      w_special    = 1'b1;
      w_specialRes = w_gntX;
    end else if (w_gntX[T]) begin
      w_special    = 1'b1;
      w_specialRes = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    end else if (&w_gntX[T-1:M]) begin
      w_special    = 1'b1;
      w_specialRes = w_gntX;
    end
  end
`else
  // Without the bypass every accepted operand is sent to the unit.
  assign w_special    = 1'b0;
  assign w_specialRes = w_gntX;
`endif

  // Main sequencer. The operand and grant are captured on accept and held
  // until the response handshake; the result and id are captured only in
  // WAIT, so stray finish pulses in any other state leave them untouched.
  // The pointer advances only on the response handshake, so an aborted
  // (reset) transaction never moves it.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_sqX    <= '0;
      r_rspId  <= '0;
      r_rspRes <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_sqX <= w_gntX;
            r_gnt <= w_gnt;
            if (w_special) begin
              r_rspRes <= w_specialRes;
              r_rspId  <= w_gnt;
              r_state  <= S_RESP;
            end else begin
              r_state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (sq_finish) begin
            r_rspRes <= sq_res;
            r_rspId  <= r_gnt;
            r_state  <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_ptr   <= wrapIdx(r_gnt, 1);
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // State-decoded outputs: the start pulse is exactly the single ISSUE
  // cycle, and the response is valid for as long as RESP lasts.
  assign sq_start  = (r_state == S_ISSUE);
  assign rsp_valid = (r_state == S_RESP);
  assign busy      = (r_state != S_IDLE);
  assign sq_x      = r_sqX;
  assign rsp_id    = r_rspId;
  assign rsp_res   = r_rspRes;

endmodule

// File: tb/tb_fphub_sqrt_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fphub_sqrt_arbiter
//
// Bench for fphub_sqrt_arbiter at default widths (NREQ=4, 32-bit operands).
// A stub sqrt unit answers each start pulse after a programmable latency.
// Accepts are predicted by a round-robin reference model and pushed into a
// scoreboard; a monitor pops and compares on every response handshake.
// Directed sequences cover timing, fairness, back-pressure, the special
// bypass (FPHUB_SQRT_SPECIAL_EN), reset abort and stray finish pulses,
// followed by a randomized phase and a drain.
// ---------------------------------------------------------------------------
module tb_fphub_sqrt_arbiter;

  localparam int NREQ = 4;

`ifdef FPHUB_SQRT_SPECIAL_EN
  localparam bit SPECIAL_EN = 1'b1;
`else
  localparam bit SPECIAL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_l;
  logic [3:0]  req_valid;
  logic [127:0] req_x;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_res;
  logic        sq_start;
  logic [31:0] sq_x;
  logic [31:0] sq_res;
  logic        sq_finish;
  logic        busy;

  logic [31:0] reqX [4];
  int          stubLat;
  logic        stubFinish;
  logic [31:0] stubRes;
  logic        manualFinish;
  logic [31:0] manualRes;

  assign req_x     = {reqX[3], reqX[2], reqX[1], reqX[0]};
  assign sq_finish = stubFinish | manualFinish;
  assign sq_res    = manualFinish ? manualRes : stubRes;

  always #5 clk = ~clk;

  fphub_sqrt_arbiter #(.NREQ(4), .M(23), .E(8)) dut (
    .clk       (clk),
    .rst_l     (rst_l),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_res   (rsp_res),
    .sq_start  (sq_start),
    .sq_x      (sq_x),
    .sq_res    (sq_res),
    .sq_finish (sq_finish),
    .busy      (busy)
  );

  int passCount  = 0;
  int checkCount = 0;
  int respCount  = 0;

  typedef struct {
    int          id;
    logic [31:0] res;
  } expT;

  expT         expQ [$];
  logic [31:0] startQ [$];
  int          modelPtr = 0;
  bit          issuePending = 1'b0;
  logic [3:0]  lastReady = '0;

  // What the stub unit returns for an operand: the true root for the
  // directed value, an arbitrary scramble otherwise.
  function automatic logic [31:0] stubModel(input logic [31:0] x);
    if (x == 32'h40800000) return 32'h40000000;
    return {x[15:0], x[31:16]} ^ 32'h13572468;
  endfunction

  function automatic bit isSpecial(input logic [31:0] x);
    return SPECIAL_EN && ((x[30:23] == 8'h00) || x[31] || (x[30:23] == 8'hFF));
  endfunction

  // Expected response for an accepted operand.
  function automatic logic [31:0] expectRes(input logic [31:0] x);
    if (SPECIAL_EN) begin
      if (x[30:23] == 8'h00) return x;
      if (x[31]) return 32'h7FC00000;
      if (x[30:23] == 8'hFF) return x;
    end
    return stubModel(x);
  endfunction

  function automatic logic [31:0] randOperand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: r = {r[31], 8'h00, r[22:0]};
      1: r = {1'b1, 8'h81, r[22:0]};
      2: r = {1'b0, 8'hFF, r[22:0]};
      default: r = {1'b0, 8'h7F, r[22:0]};
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic rdy);
    @(posedge clk);
    #1;
    req_valid = valid;
    rsp_ready = rdy;
  endtask

  task automatic applyReset();
    @(posedge clk);
    #1 rst_l = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_l = 1'b1;
  endtask

  task automatic waitGrant(output int idx);
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (req_ready == 4'b0 && cnt < 300);
    idx = -1;
    for (int i = 3; i >= 0; i--) if (req_ready[i]) idx = i;
    if (req_ready == 4'b0) checkOutput("grantTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitRsp();
    int cnt;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!rsp_valid && cnt < 300);
    if (!rsp_valid) checkOutput("rspTimeout", 32'd0, 32'd1);
  endtask

  task automatic waitIdle();
    int cnt;
    cnt = 0;
    @(negedge clk);
    while (busy && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    if (busy) checkOutput("idleTimeout", 32'd1, 32'd0);
  endtask

  // One randomized cycle: retire requests accepted last cycle, raise new
  // ones at random, and toss the response back-pressure.
  task automatic randomStimulus(input bit newReqs);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (req_valid[i] && lastReady[i]) req_valid[i] = 1'b0;
      if (newReqs && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        req_valid[i] = 1'b1;
        reqX[i]      = randOperand();
      end
    end
    rsp_ready = newReqs ? ($urandom_range(0, 3) != 0) : 1'b1;
    stubLat   = $urandom_range(1, 6);
  endtask

  // Stub sqrt unit: answers a start pulse after stubLat cycles.
  initial begin
    logic [31:0] capX;
    stubFinish = 1'b0;
    stubRes    = '0;
    forever begin
      @(negedge clk);
      if (sq_start && rst_l) begin
        capX = sq_x;
        repeat (stubLat) @(posedge clk);
        #1;
        stubFinish = 1'b1;
        stubRes    = stubModel(capX);
        @(posedge clk);
        #1 stubFinish = 1'b0;
      end
    end
  end

  // Monitor: predicts every accept with the round-robin rule, checks the
  // start pulse and operand, and scores every response handshake.
  always @(negedge clk) begin
    int          g;
    bit          found;
    expT         e;
    logic [31:0] x;
    if (!rst_l) begin
      modelPtr     = 0;
      issuePending = 1'b0;
      lastReady    = '0;
      expQ.delete();
      startQ.delete();
    end else begin
      lastReady = req_ready;
      if (issuePending || sq_start) begin
        checkOutput("sqStartTiming", {31'd0, sq_start}, {31'd0, issuePending});
        if (sq_start) begin
          if (startQ.size() == 0) begin
            checkOutput("sqStartUnexpected", 32'd1, 32'd0);
          end else begin
            x = startQ.pop_front();
            checkOutput("sqOperand", sq_x, x);
          end
        end
      end
      issuePending = 1'b0;
      if (busy) begin
        checkOutput("readyWhileBusy", {28'd0, req_ready}, 32'd0);
      end else if (req_valid != 4'b0) begin
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < NREQ; k++) begin
          if (!found && req_valid[(modelPtr + k) % NREQ]) begin
            found = 1'b1;
            g     = (modelPtr + k) % NREQ;
          end
        end
        checkOutput("grant", {28'd0, req_ready}, 32'd1 << g);
        e.id  = g;
        e.res = expectRes(reqX[g]);
        expQ.push_back(e);
        if (!isSpecial(reqX[g])) begin
          startQ.push_back(reqX[g]);
          issuePending = 1'b1;
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("rspUnexpected", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput("rspId", {30'd0, rsp_id}, e.id);
          checkOutput("rspRes", rsp_res, e.res);
          modelPtr = (e.id + 1) % NREQ;
          respCount++;
        end
      end else if (rsp_valid && expQ.size() == 0) begin
        checkOutput("rspUnexpected", 32'd1, 32'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int cyc;
    int finCyc;
    bit sawFin;
    bit sawRsp;
    rst_l        = 1'b0;
    req_valid    = '0;
    rsp_ready    = 1'b1;
    manualFinish = 1'b0;
    manualRes    = '0;
    stubLat      = 1;
    for (int i = 0; i < 4; i++) reqX[i] = '0;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstRspValid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rstSqStart", {31'd0, sq_start}, 32'd0);
    checkOutput("rstSqX", sq_x, 32'd0);
    checkOutput("rstRspId", {30'd0, rsp_id}, 32'd0);
    checkOutput("rstRspRes", rsp_res, 32'd0);
    checkOutput("rstReqReady", {28'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1 rst_l = 1'b1;

    // Single request from requester 2, unit latency 30
    $display("[TB] directed: single request timing");
    reqX[2] = 32'h40800000;
    stubLat = 30;
    applyStimulus(4'b0100, 1'b1);
    @(negedge clk);
    checkOutput("t1Accept", {28'd0, req_ready}, 32'h4);
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    checkOutput("t1StartHigh", {31'd0, sq_start}, 32'd1);
    checkOutput("t1SqX", sq_x, 32'h40800000);
    @(negedge clk);
    checkOutput("t1StartLow", {31'd0, sq_start}, 32'd0);
    checkOutput("t1SqXHeld", sq_x, 32'h40800000);
    cyc    = 2;
    finCyc = -1;
    while (!rsp_valid && cyc < 100) begin
      if (sq_finish) finCyc = cyc;
      @(negedge clk);
      cyc++;
    end
    checkOutput("t1Latency", cyc, 32'd32);
    checkOutput("t1AfterFinish", cyc, finCyc + 1);
    checkOutput("t1RspId", {30'd0, rsp_id}, 32'd2);
    checkOutput("t1RspRes", rsp_res, 32'h40000000);
    waitIdle();

    // Fairness with all requesters held valid
    $display("[TB] directed: round-robin order");
    applyReset();
    for (int i = 0; i < 4; i++) reqX[i] = 32'h3F800000 + (i << 20);
    stubLat = 1;
    applyStimulus(4'b1111, 1'b1);
    for (int k = 0; k < 6; k++) begin
      waitGrant(idx);
      checkOutput("rrOrder", idx, k % 4);
      checkOutput("rrOneHot", $countones(req_ready), 32'd1);
    end
    applyStimulus(4'b0000, 1'b1);
    waitIdle();

    // Response back-pressure for 5 cycles
    $display("[TB] directed: response stall");
    reqX[1] = 32'h40100000;
    reqX[0] = 32'h40400000;
    stubLat = 4;
    applyStimulus(4'b0010, 1'b0);
    waitGrant(idx);
    checkOutput("stallGrant", idx, 32'd1);
    applyStimulus(4'b0001, 1'b0);
    waitRsp();
    for (int c = 0; c < 5; c++) begin
      checkOutput("stallValid", {31'd0, rsp_valid}, 32'd1);
      checkOutput("stallId", {30'd0, rsp_id}, 32'd1);
      checkOutput("stallRes", rsp_res, expectRes(32'h40100000));
      checkOutput("stallNoReady", {28'd0, req_ready}, 32'd0);
      checkOutput("stallNoStart", {31'd0, sq_start}, 32'd0);
      if (c < 4) @(negedge clk);
    end
    applyStimulus(4'b0001, 1'b1);
    @(negedge clk);
    checkOutput("stallHandshake", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    checkOutput("stallDoneValid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("stallDoneIdle", {31'd0, busy}, 32'd0);
    checkOutput("stallNextGrant", {28'd0, req_ready}, 32'h1);
    applyStimulus(4'b0000, 1'b1);
    waitIdle();

    // Negative operand: bypassed with the macro, issued without it
    $display("[TB] directed: negative operand");
    reqX[0] = 32'hC0800000;
    stubLat = 2;
    applyStimulus(4'b0001, 1'b1);
    waitGrant(idx);
    checkOutput("specGrant", idx, 32'd0);
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
`ifdef FPHUB_SQRT_SPECIAL_EN
    checkOutput("specRspValid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("specRspRes", rsp_res, 32'h7FC00000);
    checkOutput("specNoStart", {31'd0, sq_start}, 32'd0);
`else
    checkOutput("specIssued", {31'd0, sq_start}, 32'd1);
    checkOutput("specSqX", sq_x, 32'hC0800000);
`endif
    waitIdle();

    // Reset in the middle of WAIT
    $display("[TB] directed: reset abort");
    reqX[2] = 32'h41100000;
    stubLat = 20;
    applyStimulus(4'b0100, 1'b1);
    waitGrant(idx);
    applyStimulus(4'b0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_l = 1'b0;
    #1;
    checkOutput("abortBusy", {31'd0, busy}, 32'd0);
    checkOutput("abortRspValid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("abortSqStart", {31'd0, sq_start}, 32'd0);
    checkOutput("abortSqX", sq_x, 32'd0);
    checkOutput("abortRspId", {30'd0, rsp_id}, 32'd0);
    checkOutput("abortRspRes", rsp_res, 32'd0);
    checkOutput("abortReqReady", {28'd0, req_ready}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst_l = 1'b1;
    sawFin = 1'b0;
    sawRsp = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (sq_finish) sawFin = 1'b1;
      if (rsp_valid) sawRsp = 1'b1;
    end
    checkOutput("abortLateFinish", {31'd0, sawFin}, 32'd1);
    checkOutput("abortNoResponse", {31'd0, sawRsp}, 32'd0);
    applyStimulus(4'b1111, 1'b1);
    waitGrant(idx);
    checkOutput("abortPtrZero", idx, 32'd0);
    applyStimulus(4'b0000, 1'b1);
    waitIdle();

    // Stray finish pulses in IDLE and in RESP
    $display("[TB] directed: stray finish");
    manualRes = 32'hDEADBEEF;
    @(posedge clk);
    #1 manualFinish = 1'b1;
    @(posedge clk);
    #1 manualFinish = 1'b0;
    @(negedge clk);
    checkOutput("strayIdleBusy", {31'd0, busy}, 32'd0);
    checkOutput("strayIdleValid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("strayIdleRes", rsp_res, expectRes(reqX[0]));
    reqX[3] = 32'h40490FDB;
    stubLat = 3;
    applyStimulus(4'b1000, 1'b0);
    waitGrant(idx);
    checkOutput("strayGrant", idx, 32'd3);
    applyStimulus(4'b0000, 1'b0);
    waitRsp();
    @(posedge clk);
    #1 manualFinish = 1'b1;
    @(posedge clk);
    #1 manualFinish = 1'b0;
    @(negedge clk);
    checkOutput("strayRespValid", {31'd0, rsp_valid}, 32'd1);
    checkOutput("strayRespId", {30'd0, rsp_id}, 32'd3);
    checkOutput("strayRespRes", rsp_res, expectRes(32'h40490FDB));
    applyStimulus(4'b0000, 1'b1);
    waitIdle();

    // Randomized traffic, then drain
    $display("[TB] random phase");
    for (int n = 0; n < 4000; n++) randomStimulus(1'b1);
    for (int n = 0; n < 2000; n++) begin
      if (req_valid == 4'b0 && !busy && expQ.size() == 0) break;
      randomStimulus(1'b0);
    end
    repeat (2) @(negedge clk);
    checkOutput("drained", expQ.size(), 32'd0);
    checkOutput("randomActivity", {31'd0, respCount > 100}, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/fphub_sqrt_arbiter.md
# fphub_sqrt_arbiter

Round-robin arbiter and sequencer that shares one iterative FPHUB square-root unit (`FPHUB_sqrt`) among `NREQ` requesters. It accepts one operand at a time, pulses the unit's `start` with the granted operand, and waits for `finish`. It then returns the result with the requester's index on a single valid/ready response channel. It sits between the requester ports and the sqrt datapath; only one operation is in flight.

## Interface

- `NREQ`, 4: number of requesters, ≥2.
- `M`, 23: mantissa width.
- `E`, 8: exponent width.
- `T` (local), M+E: operand MSB index. Operands are T+1 bits.
- `IDW` (local), $clog2(NREQ): response id width.

- `clk` in 1: clock.
- `rst_l` in 1: reset, asynchronous, active-low.
- `req_valid` in NREQ: per-requester request.
- `req_x` in NREQ*(T+1): operands, requester i at bits [i*(T+1) +: T+1].
- `req_ready` out NREQ: one-hot accept.
- `rsp_valid` out 1: result valid.
- `rsp_ready` in 1: consumer accepts result.
- `rsp_id` out IDW: index of served requester.
- `rsp_res` out T+1: result.
- `sq_start` out 1: start pulse to sqrt unit.
- `sq_x` out T+1: operand to sqrt unit.
- `sq_res` in T+1: unit result.
- `sq_finish` in 1: unit done pulse.
- `busy` out 1: high in any state other than IDLE.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - Grant goes to the first i with `req_valid[i]`, searching from `ptr` upward mod NREQ.
  - `req_ready[g]` is driven combinationally high for the grant only.
  - On accept, latch `req_x[g]` into `sq_x` and latch `g`, then go to ISSUE.
  - With no valid requests, stay in IDLE.
- **ISSUE**
  - `sq_start`=1 for exactly one cycle, with `sq_x` stable.
  - Next state: WAIT.
- **WAIT**
  - Hold `sq_x`.
  - On `sq_finish`, capture `sq_res` into `rsp_res`, set `rsp_id`=g, then go to RESP.
- **RESP**
  - `rsp_valid`=1, with `rsp_id` and `rsp_res` stable until `rsp_valid && rsp_ready`.
  - On that handshake: `ptr`←(g+1) mod NREQ, state←IDLE.
- `sq_finish` outside WAIT is ignored.
- Requesters must hold `req_valid` and `req_x` until accepted. The arbiter never drops a pending request, and `ptr` guarantees starvation freedom.
- Results pass through unmodified; the arbiter does no arithmetic on the unit path.

## Timing

- Reset values (async on `rst_l` low): state IDLE, `ptr`=0, `req_ready`=0, `sq_start`=0, `sq_x`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_res`=0, `busy`=0.
- Accept at cycle 0, `sq_start` at cycle 1, WAIT from cycle 2.
  - `sq_finish` at cycle k gives `rsp_valid` at k+1.
  - Total latency is the unit latency plus 2.
- Earliest next accept is the cycle after the response handshake. A handshake in the first RESP cycle means IDLE at the next cycle.
- `req_ready` is never asserted outside IDLE.
- Reset mid-operation aborts the transaction and returns to the reset values. No response is produced for the aborted request. The unit shares `rst_l`.

## Configuration

- Macro `FPHUB_SQRT_SPECIAL_EN`, when defined, enables a special-case bypass. In IDLE, the accepted operand is classified and special cases go straight to RESP on the next cycle, without ISSUE or `sq_start`:
  - Exponent all zeros: result = operand (signed zero).
  - Sign=1 with nonzero exponent: result = canonical NaN, i.e. sign 0, exponent all ones, mantissa MSB 1, rest 0 (0x7FC00000 at default widths).
  - Exponent all ones with sign 0: result = operand.
- When not defined, every operand goes to the unit.

## Test plan

- Requester 2 sends x=0x40800000; stub returns 0x40000000 with `sq_finish` 30 cycles after start.
  - `sq_start` is high for one cycle at cycle 1 with `sq_x`=0x40800000.
  - `rsp_valid` rises the cycle after `sq_finish`, with `rsp_id`=2 and `rsp_res`=0x40000000.
- All 4 `req_valid` held high continuously, `rsp_ready`=1 → service order 0,1,2,3,0,1. Exactly one `req_ready` bit per accept.
- `rsp_ready`=0 for 5 cycles in RESP → `rsp_id` and `rsp_res` stable, no `req_ready`, no `sq_start`. The handshake completes on the cycle `rsp_ready` rises.
- Macro defined, x=0xC0800000 → `rsp_valid` at cycle 1 with `rsp_res`=0x7FC00000 and `sq_start` never asserted. Macro undefined, same stimulus → the operand is issued to the unit.
- `rst_l` pulsed low during WAIT → all outputs 0 asynchronously and `ptr`=0. A `sq_finish` after reset release is ignored and no `rsp_valid` appears.
- Spurious `sq_finish` in IDLE, or a second pulse in RESP → no state change and `rsp_res` unchanged.
